// File: rtl/convolver_control_if.sv
// Handshake and strobe bundle between the frame sequencer and its neighbours.
// master: upstream source/observer side; slave: the convolver_control block.
interface convolver_control_if;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic       weight_write;
  logic [3:0] weight_addr;
  logic       three_shift;
  logic       out_valid;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output in_valid,
    input  in_ready,
    input  weight_write,
    input  weight_addr,
    input  three_shift,
    input  out_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  in_valid,
    output in_ready,
    output weight_write,
    output weight_addr,
    output three_shift,
    output out_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/convolver_control.sv
// Frame sequencer for the 3x3 convolver: loads nine kernel weights, then streams
// IMG_W x IMG_H pixels, flagging full windows and pulsing done at end of frame.
module convolver_control #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                clk,
  input  logic                reset,
  convolver_control_if.slave  bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(2);
  localparam logic [RW-1:0] ROW_WIN  = RW'(2);
  localparam logic [3:0]    TAP_LAST = 4'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [3:0]    weight_addr_reg, weight_addr_next;
  logic [CW-1:0] col_reg, col_next;
  logic [RW-1:0] row_reg, row_next;
  logic          out_valid_reg, out_valid_next;

  logic in_load;
  logic in_stream;
  logic accept;

  assign in_load   = (state_reg == LOAD_W);
  assign in_stream = (state_reg == STREAM);
  assign accept    = bus.in_valid && (in_load || in_stream);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      weight_addr_reg <= 4'd0;
      col_reg         <= '0;
      row_reg         <= '0;
      out_valid_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      weight_addr_reg <= weight_addr_next;
      col_reg         <= col_next;
      row_reg         <= row_next;
      out_valid_reg   <= out_valid_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    weight_addr_next = weight_addr_reg;
    col_next         = col_reg;
    row_next         = row_reg;
    out_valid_next   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next       = LOAD_W;
          weight_addr_next = 4'd0;
          col_next         = '0;
          row_next         = '0;
        end
      end

      LOAD_W: begin
        if (accept) begin
          if (weight_addr_reg == TAP_LAST) begin
            state_next       = STREAM;
            weight_addr_next = 4'd0;
          end else begin
            weight_addr_next = weight_addr_reg + 4'd1;
          end
        end
      end

      STREAM: begin
        if (accept) begin
          // Window result appears one cycle later, aligned with the datapath MAC register.
          out_valid_next = (row_reg >= ROW_WIN) && (col_reg >= COL_WIN);
          if (col_reg == COL_LAST) begin
            col_next = '0;
            if (row_reg == ROW_LAST) begin
              state_next = DONE;
            end else begin
              row_next = row_reg + RW'(1);
            end
          end else begin
            col_next = col_reg + CW'(1);
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready     = in_load || in_stream;
  assign bus.weight_write = bus.in_valid && in_load;
  assign bus.three_shift  = bus.in_valid && in_stream;
  assign bus.weight_addr  = weight_addr_reg;
  assign bus.out_valid    = out_valid_reg;
  assign bus.busy         = (state_reg != IDLE);
  assign bus.done         = (state_reg == DONE);

endmodule

// File: tb/tb_convolver_control.sv
// Directed bench for convolver_control at 8x8, 3x3 and 4x4; a cycle-stamped
// scoreboard predicts out_valid/done from the accepted-beat sequence.
module tb_convolver_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       start_v[3];
  logic       in_valid_v[3];
  logic       in_ready_m[3];
  logic       ww_m[3];
  logic [3:0] wa_m[3];
  logic       ts_m[3];
  logic       ov_m[3];
  logic       busy_m[3];
  logic       done_m[3];

  convolver_control_if bus[3] ();

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int W = (gi == 0) ? 8 : (gi == 1) ? 3 : 4;
      assign bus[gi].start    = start_v[gi];
      assign bus[gi].in_valid = in_valid_v[gi];
      assign in_ready_m[gi]   = bus[gi].in_ready;
      assign ww_m[gi]         = bus[gi].weight_write;
      assign wa_m[gi]         = bus[gi].weight_addr;
      assign ts_m[gi]         = bus[gi].three_shift;
      assign ov_m[gi]         = bus[gi].out_valid;
      assign busy_m[gi]       = bus[gi].busy;
      assign done_m[gi]       = bus[gi].done;

      convolver_control #(.IMG_W(W), .IMG_H(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus[gi])
      );
    end
  endgenerate

  int wv[3] = '{8, 3, 4};

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ov_q[$];
  int done_q[$];
  int cnt_ww, cnt_ts, cnt_ov, cnt_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Compare one instance's outputs at mid-cycle against expectations and the scoreboard.
  task automatic observe(input int k, input logic e_ww, input logic e_ts,
                         input logic e_ir, input logic e_busy, input logic [3:0] e_wa);
    logic e_ov, e_done;
    e_ov   = (ov_q.size() > 0) && (ov_q[0] == cyc);
    e_done = (done_q.size() > 0) && (done_q[0] == cyc);
    if (e_ov)   void'(ov_q.pop_front());
    if (e_done) void'(done_q.pop_front());
    if (ww_m[k] === 1'b1) cnt_ww++;
    if (ts_m[k] === 1'b1) cnt_ts++;
    if (ov_m[k] === 1'b1) cnt_ov++;
    if (done_m[k] === 1'b1) cnt_done++;
    chk("out_valid",    ov_m[k],       e_ov);
    chk("done",         done_m[k],     e_done);
    chk("weight_write", ww_m[k],       e_ww);
    chk("three_shift",  ts_m[k],       e_ts);
    chk("in_ready",     in_ready_m[k], e_ir);
    chk("busy",         busy_m[k],     e_busy);
    chk("weight_addr",  wa_m[k],       e_wa);
  endtask

  task automatic drive(input int k, input logic sv, input logic iv);
    @(posedge clk);
    #1;
    start_v[k]    = sv;
    in_valid_v[k] = iv;
    @(negedge clk);
  endtask

  // One frame on instance k. dens = in_valid percentage; poke re-asserts start
  // mid-frame and in DONE; abort_px >= 0 pulls reset after that many pixels.
  task automatic run_frame(input int k, input int dens, input bit poke,
                           input int abort_px, output int len);
    int   w, total, n, p, s_cyc;
    logic iv;
    w     = wv[k];
    total = 9 + w * w;
    n     = 0;
    len   = 0;
    cnt_ww = 0; cnt_ts = 0; cnt_ov = 0; cnt_done = 0;

    drive(k, 1'b1, 1'($urandom_range(0, 1)));
    s_cyc = cyc;
    observe(k, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    while (n < total) begin
      iv = ($urandom_range(1, 100) <= dens);
      drive(k, poke ? 1'($urandom_range(0, 1)) : 1'b0, iv);
      observe(k, iv && (n < 9), iv && (n >= 9), 1'b1, 1'b1, (n < 9) ? 4'(n) : 4'd0);
      if (abort_px >= 0 && n - 9 == abort_px) begin
        in_valid_v[k] = 1'b1;
        reset = 1'b0;
        #1;
        chk("rst_three_shift", ts_m[k],       1'b0);
        chk("rst_in_ready",    in_ready_m[k], 1'b0);
        chk("rst_busy",        busy_m[k],     1'b0);
        chk("rst_out_valid",   ov_m[k],       1'b0);
        chk("rst_done",        done_m[k],     1'b0);
        chk("rst_weight_addr", wa_m[k],       4'd0);
        ov_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        start_v[k] = 1'b0;
        return;
      end
      if (iv) begin
        if (n >= 9) begin
          p = n - 9;
          if ((p / w) >= 2 && (p % w) >= 2) ov_q.push_back(cyc + 1);
          if (p == w * w - 1) done_q.push_back(cyc + 1);
        end
        n++;
      end
    end

    drive(k, poke, 1'($urandom_range(0, 1)));
    chk("done_in_done_cycle", done_m[k], 1'b1);
    observe(k, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    len = cyc - s_cyc + 1;
    start_v[k]    = 1'b0;
    in_valid_v[k] = 1'b0;

    chk("count_weight_write", cnt_ww,   9);
    chk("count_three_shift",  cnt_ts,   w * w);
    chk("count_out_valid",    cnt_ov,   (w - 2) * (w - 2));
    chk("count_done",         cnt_done, 1);
    chk("ov_pending",         ov_q.size(),   0);
    chk("done_pending",       done_q.size(), 0);
    $display("frame inst=%0d %0dx%0d dens=%0d poke=%0d len=%0d ww=%0d ts=%0d ov=%0d",
             k, w, w, dens, poke, len, cnt_ww, cnt_ts, cnt_ov);
  endtask

  initial begin
    int len;
    for (int i = 0; i < 3; i++) begin
      start_v[i]    = 1'b0;
      in_valid_v[i] = 1'b0;
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_busy",     busy_m[i],     1'b0);
      chk("reset_in_ready", in_ready_m[i], 1'b0);
      chk("reset_done",     done_m[i],     1'b0);
      chk("reset_ov",       ov_m[i],       1'b0);
      chk("reset_wa",       wa_m[i],       4'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // in_valid while IDLE with no start must be inert
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, 1'b1);
      observe(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    end
    in_valid_v[0] = 1'b0;
    $display("idle in_valid probe done");

    run_frame(0, 100, 1'b0, -1, len);
    chk("len_8x8", len, 75);

    run_frame(1, 100, 1'b0, -1, len);
    chk("len_3x3", len, 1 + 9 + 9 + 1);

    run_frame(2, 50, 1'b0, -1, len);
    run_frame(2, 50, 1'b0, -1, len);

    // start poked mid-frame and in DONE, then a new frame right after DONE
    run_frame(2, 70, 1'b1, -1, len);
    run_frame(2, 100, 1'b0, -1, len);
    chk("len_4x4_back_to_back", len, 1 + 9 + 16 + 1);

    // abort at row=3, col=5, then no frame without a new start
    run_frame(0, 100, 1'b0, 3 * 8 + 5, len);
    $display("abort applied on inst 0");
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, 1'b1);
      observe(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    end
    in_valid_v[0] = 1'b0;
    run_frame(0, 100, 1'b0, -1, len);
    chk("len_8x8_after_abort", len, 75);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
